// File: rtl/cache_ahb_burst_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the cache line burst engine.
package cache_ahb_burst_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } ahb_htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_INCR4  = 3'b011,
        HBURST_INCR8  = 3'b101,
        HBURST_INCR16 = 3'b111
    } ahb_hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADR,
        ST_BURST,
        ST_LAST
    } cache_ahb_state_t;

    // Fixed-length INCR encodings exist only for 4/8/16 beats; anything else uses open INCR.
    function automatic ahb_hburst_t hburst_for(input int beats);
        case (beats)
            1:       return HBURST_SINGLE;
            4:       return HBURST_INCR4;
            8:       return HBURST_INCR8;
            16:      return HBURST_INCR16;
            default: return HBURST_INCR;
        endcase
    endfunction

endpackage

// File: rtl/cache_ahb_burst_beat_counter.sv
// Beat index counter: advances on en_i, wraps to 0 after BEATS-1, clr_i forces 0.
module ahb_beat_counter #(
    parameter int W     = 4,
    parameter int BEATS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    localparam logic [W-1:0] TERM = W'(BEATS - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == TERM);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = last_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cache_ahb_burst.sv
// Turns one cache line request into a single AHB-Lite incrementing burst (fetch or writeback).
// Optional bus error abort is enabled by defining CACHE_AHB_BUS_ERR_EN.
module cache_ahb_burst
    import cache_ahb_burst_pkg::*;
#(
    parameter int PA_BITS = 32,
    parameter int AHBW    = 32,
    parameter int LINELEN = 512,
    parameter int LOGBWPL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [AHBW-1:0]    ReadDataWord,
    input  logic               FlushStage,
    output logic               CacheBusAck,
    output logic               CacheBusCommitted,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               SelBusBeat,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic [PA_BITS-1:0] HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HBURST,
    output logic [2:0]         HSIZE,
    output logic [AHBW-1:0]    HWDATA,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HRDATA
`ifdef CACHE_AHB_BUS_ERR_EN
    ,
    input  logic               HRESP,
    output logic               BusErr
`endif
);

    localparam int          BEATS      = LINELEN / AHBW;
    localparam int          BYTE_SHIFT = $clog2(AHBW / 8);
    localparam logic [2:0]  HSIZE_VAL  = 3'(BYTE_SHIFT);
    localparam ahb_hburst_t HBURST_VAL = hburst_for(BEATS);

    cache_ahb_state_t   state_q, state_d;
    ahb_htrans_t        htrans;
    logic [PA_BITS-1:0] base_q;
    logic               write_q;
    logic [AHBW-1:0]    hwdata_q;
    logic [LOGBWPL-1:0] adr_beat, data_beat;
    logic               adr_last, data_last;
    logic               start, adr_phase, in_data, data_phase, abort;
    logic               adr_accept, data_accept;

    assign start      = (state_q == ST_IDLE) && (|CacheBusRW) && !FlushStage;
    assign adr_phase  = (state_q == ST_ADR) || (state_q == ST_BURST);
    assign in_data    = (state_q == ST_BURST) || (state_q == ST_LAST);

`ifdef CACHE_AHB_BUS_ERR_EN
    logic err_q;
    // Once an error is seen the LAST cycle carries no data phase, only the error ack.
    assign data_phase = in_data && !err_q;
    assign abort      = data_phase && HRESP;
    assign BusErr     = (state_q == ST_LAST) && err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (abort)
            err_q <= 1'b1;
        else if (state_d == ST_IDLE)
            err_q <= 1'b0;
    end
`else
    assign data_phase = in_data;
    assign abort      = 1'b0;
`endif

    assign adr_accept  = adr_phase && HREADY && !abort;
    assign data_accept = data_phase && HREADY && !abort;

    ahb_beat_counter #(.W(LOGBWPL), .BEATS(BEATS)) u_adr_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (adr_accept),
        .clr_i  (abort),
        .cnt_o  (adr_beat),
        .last_o (adr_last)
    );

    ahb_beat_counter #(.W(LOGBWPL), .BEATS(BEATS)) u_data_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (data_accept),
        .clr_i  (abort),
        .cnt_o  (data_beat),
        .last_o (data_last)
    );

    always_comb begin
        state_d     = state_q;
        htrans      = HTRANS_IDLE;
        CacheBusAck = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_ADR;
            end
            ST_ADR: begin
                htrans = HTRANS_NONSEQ;
                if (HREADY)
                    state_d = (BEATS > 1) ? ST_BURST : ST_LAST;
            end
            ST_BURST: begin
                htrans = HTRANS_SEQ;
                if (abort || (HREADY && adr_last))
                    state_d = ST_LAST;
            end
            ST_LAST: begin
`ifdef CACHE_AHB_BUS_ERR_EN
                if (err_q) begin
                    CacheBusAck = 1'b1;
                    state_d     = ST_IDLE;
                end else
`endif
                if (HREADY && data_last && !abort) begin
                    CacheBusAck = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            write_q  <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                base_q  <= CacheBusAdr;
                write_q <= CacheBusRW[0];
            end
            // Word is picked while its address phase is up, so it lands in its own data phase.
            if (adr_accept && write_q)
                hwdata_q <= ReadDataWord;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_fetch
            logic [AHBW-1:0] word_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    word_q <= '0;
                else if (data_accept && !write_q && (data_beat == LOGBWPL'(gi)))
                    word_q <= HRDATA;
            end
            assign FetchBuffer[gi*AHBW +: AHBW] = word_q;
        end
    endgenerate

    assign HTRANS            = htrans;
    assign HADDR             = adr_phase ? base_q + (PA_BITS'(adr_beat) << BYTE_SHIFT) : '0;
    assign HWRITE            = adr_phase && write_q;
    assign HBURST            = adr_phase ? HBURST_VAL : 3'b000;
    assign HSIZE             = adr_phase ? HSIZE_VAL : 3'b000;
    assign HWDATA            = hwdata_q;
    assign BeatCount         = adr_beat;
    assign SelBusBeat        = write_q && (state_q != ST_IDLE);
    assign CacheBusCommitted = (state_q != ST_IDLE);

endmodule
